// File: rtl/dma_bus_arbiter.sv
// Wishbone bus-ownership arbiter: CPU versus NDMA DMA masters, with round-robin
// DMA selection, a burst limit, a guaranteed CPU slot and an ack-timeout watchdog.
module dma_bus_arbiter #(
  parameter int NDMA        = 2,
  parameter int MAXBURST    = 16,
  parameter int CPU_SLOT    = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic            clk_p,
  input  logic            rst_n,
  input  logic            cpu_stb,
  input  logic            global_ack,
  input  logic [NDMA-1:0] dma_req,
  input  logic [NDMA-1:0] dma_stb,
  output logic            cpu_gnt,
  output logic [NDMA-1:0] dma_gnt,
  output logic [2:0]      owner,
  output logic            bus_err
);

  typedef enum logic [1:0] {CPU_OWN, HANDOVER, DMA_OWN} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      rr_reg, rr_next;
  logic [2:0]      win_reg, win_next;
  logic [7:0]      slot_cnt_reg, slot_cnt_next;
  logic            slot_pend_reg, slot_pend_next;
  logic [7:0]      burst_cnt_reg, burst_cnt_next;
  logic [9:0]      to_cnt_reg, to_cnt_next;
  logic            cpu_gnt_next;
  logic [NDMA-1:0] dma_gnt_next;
  logic [2:0]      owner_next;
  logic            bus_err_next;

  logic [NDMA-1:0] win_oh;
  logic [NDMA-1:0] hi_req;
  logic [NDMA-1:0] cand;
  logic [2:0]      pick;
  logic            found;
  logic            req_w, stb_w, stall, slot_expired;
  logic            timeout, release_now;

  for (genvar gi = 0; gi < NDMA; gi++) begin : g_win_oh
    assign win_oh[gi] = (win_reg == 3'(gi));
  end

  assign req_w        = |(dma_req & win_oh);
  assign stb_w        = |(dma_stb & win_oh);
  assign stall        = stb_w && !global_ack;
  assign slot_expired = !slot_pend_reg || (slot_cnt_reg == 8'(CPU_SLOT));

  // Round robin: prefer requesters above the last winner, otherwise wrap to the lowest.
  always_comb begin
    hi_req = '0;
    pick   = 3'd0;
    found  = 1'b0;
    for (int i = 0; i < NDMA; i++) begin
      hi_req[i] = dma_req[i] && (i > int'(rr_reg));
    end
    cand = (hi_req != '0) ? hi_req : dma_req;
    for (int i = 0; i < NDMA; i++) begin
      if (cand[i] && !found) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_next        = rr_reg;
    win_next       = win_reg;
    slot_cnt_next  = slot_cnt_reg;
    slot_pend_next = slot_pend_reg;
    burst_cnt_next = burst_cnt_reg;
    to_cnt_next    = to_cnt_reg;
    bus_err_next   = 1'b0;
    timeout        = 1'b0;
    release_now    = 1'b0;
    case (state_reg)
      CPU_OWN: begin
        if (slot_pend_reg && (slot_cnt_reg != 8'(CPU_SLOT))) slot_cnt_next = slot_cnt_reg + 8'd1;
        if ((|dma_req) && !cpu_stb && slot_expired) begin
          state_next     = HANDOVER;
          win_next       = pick;
          slot_pend_next = 1'b0;
        end
      end
      HANDOVER: begin
        if (req_w) begin
          state_next     = DMA_OWN;
          rr_next        = win_reg;
          burst_cnt_next = 8'd0;
          to_cnt_next    = 10'd0;
        end else begin
          state_next = CPU_OWN;
        end
      end
      DMA_OWN: begin
        if (global_ack && stb_w && (burst_cnt_reg != 8'(MAXBURST))) burst_cnt_next = burst_cnt_reg + 8'd1;
        to_cnt_next = stall ? to_cnt_reg + 10'd1 : 10'd0;
        timeout     = stall && (to_cnt_reg == 10'(ACK_TIMEOUT - 1));
        // A saturated burst still waits for the in-flight strobe to drop.
        release_now = (!req_w && !stb_w) ||
                      ((burst_cnt_reg == 8'(MAXBURST)) && !stb_w) ||
                      timeout;
        if (release_now) begin
          state_next     = CPU_OWN;
          slot_cnt_next  = 8'd0;
          slot_pend_next = 1'b1;
          burst_cnt_next = 8'd0;
          to_cnt_next    = 10'd0;
          bus_err_next   = timeout;
        end
      end
      default: state_next = CPU_OWN;
    endcase
    cpu_gnt_next = (state_next == CPU_OWN);
    dma_gnt_next = (state_next == DMA_OWN) ? win_oh : '0;
    owner_next   = (state_next == DMA_OWN) ? win_reg + 3'd1 : 3'd0;
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= CPU_OWN;
      rr_reg        <= 3'(NDMA - 1);
      win_reg       <= 3'd0;
      slot_cnt_reg  <= 8'd0;
      slot_pend_reg <= 1'b0;
      burst_cnt_reg <= 8'd0;
      to_cnt_reg    <= 10'd0;
      cpu_gnt       <= 1'b1;
      dma_gnt       <= '0;
      owner         <= 3'd0;
      bus_err       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_reg        <= rr_next;
      win_reg       <= win_next;
      slot_cnt_reg  <= slot_cnt_next;
      slot_pend_reg <= slot_pend_next;
      burst_cnt_reg <= burst_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      cpu_gnt       <= cpu_gnt_next;
      dma_gnt       <= dma_gnt_next;
      owner         <= owner_next;
      bus_err       <= bus_err_next;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter (NDMA=2, MAXBURST=4, CPU_SLOT=4, ACK_TIMEOUT=64);
// outputs are packed as {cpu_gnt, dma_gnt, owner, bus_err} and checked 1 ns after each edge.
module tb_dma_bus_arbiter;

  logic       clk_p = 1'b0;
  logic       rst_n;
  logic       cpu_stb;
  logic       global_ack;
  logic [1:0] dma_req;
  logic [1:0] dma_stb;
  logic       cpu_gnt;
  logic [1:0] dma_gnt;
  logic [2:0] owner;
  logic       bus_err;

  int n_cmp = 0;
  int n_err = 0;

  dma_bus_arbiter #(
    .NDMA(2), .MAXBURST(4), .CPU_SLOT(4), .ACK_TIMEOUT(64)
  ) dut (
    .clk_p(clk_p), .rst_n(rst_n), .cpu_stb(cpu_stb), .global_ack(global_ack),
    .dma_req(dma_req), .dma_stb(dma_stb), .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
    .owner(owner), .bus_err(bus_err)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  function automatic logic [6:0] ex(logic cg, logic [1:0] dg, logic [2:0] ow, logic be);
    return {cg, dg, ow, be};
  endfunction

  task automatic chk(input string tag, input logic [6:0] expv);
    logic [6:0] obs;
    obs = {cpu_gnt, dma_gnt, owner, bus_err};
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed cg/dg/own/err=%b required %b", tag, obs, expv);
    end
  endtask

  initial begin
    rst_n = 1'b0; cpu_stb = 1'b0; global_ack = 1'b0; dma_req = 2'b00; dma_stb = 2'b00;
    tick(); tick();
    chk("reset_state", ex(1, 2'b00, 0, 0));
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", ex(1, 2'b00, 0, 0));

    // Deferred handover: request held while the CPU transaction is in flight.
    cpu_stb = 1'b1; dma_req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("defer_cpu_busy%0d", i), ex(1, 2'b00, 0, 0));
    end
    cpu_stb = 1'b0;
    tick(); chk("defer_handover", ex(0, 2'b00, 0, 0));
    tick(); chk("defer_grant", ex(0, 2'b01, 1, 0));
    dma_stb = 2'b01; global_ack = 1'b1;
    tick(); chk("defer_xfer", ex(0, 2'b01, 1, 0));
    dma_req = 2'b00; dma_stb = 2'b00; global_ack = 1'b0;
    tick(); chk("defer_normal_release", ex(1, 2'b00, 0, 0));
    $display("phase deferred handover: %0d compared", n_cmp);

    // Round robin with burst limit; CPU slot between grants.
    dma_req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      logic [1:0] eg;
      logic [2:0] eo;
      eg = (k % 2 == 0) ? 2'b10 : 2'b01;
      eo = (k % 2 == 0) ? 3'd2 : 3'd1;
      for (int i = 0; i < 4; i++) begin
        tick();
        chk($sformatf("rr%0d_slot%0d", k, i), ex(1, 2'b00, 0, 0));
      end
      tick(); chk($sformatf("rr%0d_handover", k), ex(0, 2'b00, 0, 0));
      tick(); chk($sformatf("rr%0d_grant", k), ex(0, eg, eo, 0));
      dma_stb = eg; global_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        chk($sformatf("rr%0d_ack%0d", k, i), ex(0, eg, eo, 0));
      end
      dma_stb = 2'b00; global_ack = 1'b0;
      tick(); chk($sformatf("rr%0d_burst_release", k), ex(1, 2'b00, 0, 0));
    end
    $display("phase round robin: %0d compared", n_cmp);

    // Watchdog: stalled strobe with request held.
    dma_req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wd_slot%0d", i), ex(1, 2'b00, 0, 0));
    end
    tick(); chk("wd_handover", ex(0, 2'b00, 0, 0));
    tick(); chk("wd_grant", ex(0, 2'b01, 1, 0));
    dma_stb = 2'b01;
    for (int i = 1; i < 64; i++) begin
      tick();
      chk($sformatf("wd_stall%0d", i), ex(0, 2'b01, 1, 0));
    end
    tick(); chk("wd_release_err", ex(1, 2'b00, 0, 1));
    dma_stb = 2'b00; dma_req = 2'b00;
    tick(); chk("wd_err_one_cycle", ex(1, 2'b00, 0, 0));
    $display("phase watchdog: %0d compared", n_cmp);

    // Aborted request: one-cycle pulse once the slot has expired.
    for (int i = 0; i < 4; i++) tick();
    dma_req = 2'b01;
    tick(); chk("abort_handover", ex(0, 2'b00, 0, 0));
    dma_req = 2'b00;
    tick(); chk("abort_back_cpu", ex(1, 2'b00, 0, 0));
    tick(); chk("abort_no_grant", ex(1, 2'b00, 0, 0));
    dma_req = 2'b10;
    tick(); chk("abort_noslot_handover", ex(0, 2'b00, 0, 0));
    tick(); chk("abort_next_grant", ex(0, 2'b10, 2, 0));
    $display("phase aborted request: %0d compared", n_cmp);

    // Asynchronous reset in the middle of a DMA transfer.
    dma_stb = 2'b10;
    tick(); chk("rst_pre", ex(0, 2'b10, 2, 0));
    #2 rst_n = 1'b0;
    #1 chk("rst_async", ex(1, 2'b00, 0, 0));
    tick(); chk("rst_held", ex(1, 2'b00, 0, 0));
    dma_req = 2'b00; dma_stb = 2'b00;
    rst_n = 1'b1;
    tick(); chk("rst_idle0", ex(1, 2'b00, 0, 0));
    tick(); chk("rst_idle1", ex(1, 2'b00, 0, 0));
    dma_req = 2'b11;
    tick(); chk("rst_fresh_handover", ex(0, 2'b00, 0, 0));
    tick(); chk("rst_rr_ptr_grant", ex(0, 2'b01, 1, 0));
    $display("phase reset: %0d compared", n_cmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
